// File: rtl/alu_mem_pkg.sv
// Shared constants and types for the ALU bus initiator: register map,
// ALU op encoding and the master FSM state set.
package alu_mem_pkg;

    localparam logic [1:0]  ADDR_A      = 2'd0;
    localparam logic [1:0]  ADDR_B      = 2'd1;
    localparam logic [1:0]  ADDR_OP     = 2'd2;
    localparam logic [1:0]  ADDR_EXEC   = 2'd3;
    localparam logic [7:0]  EXEC_DATA   = 8'h01;
    localparam logic [15:0] DIV0_RESULT = 16'hDEAD;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_OP,
        S_WR_EXEC,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_e;

    // First register write still needed, in map order; EXEC is always issued.
    function automatic state_e first_write(input logic need_a,
                                           input logic need_b,
                                           input logic need_op);
        state_e nxt;
        if (need_a)       nxt = S_WR_A;
        else if (need_b)  nxt = S_WR_B;
        else if (need_op) nxt = S_WR_OP;
        else              nxt = S_WR_EXEC;
        return nxt;
    endfunction

endpackage

// File: rtl/alu_mem_master_if.sv
// Command, response and memory-bus signals of the ALU bus initiator.
// The master modport is the initiator's view; slave is the environment's.
interface alu_mem_master_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;
    logic [2:0]            cmd_op;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [RES_WIDTH-1:0]  rsp_result;
    logic                  rsp_div0;
    logic                  rsp_err;

    logic                  bus_enable;
    logic                  bus_rd_wr;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wr_data;
    logic [RES_WIDTH-1:0]  bus_res_out;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, bus_res_out,
        output cmd_ready, rsp_valid, rsp_result, rsp_div0, rsp_err,
               bus_enable, bus_rd_wr, bus_addr, bus_wr_data
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, bus_res_out,
        input  cmd_ready, rsp_valid, rsp_result, rsp_div0, rsp_err,
               bus_enable, bus_rd_wr, bus_addr, bus_wr_data
    );
endinterface

// File: rtl/alu_mem_master.sv
// Bus initiator for the memory-mapped ALU: programs A/B/OP/EXEC over the bus,
// skipping writes whose value the ALU already holds, then returns the result.
module alu_mem_master
    import alu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_mem_master_if.master     bus
);

    state_e                state_q, state_d;

    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_op_q, sh_op_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [RES_WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic                  rsp_div0_q, rsp_div0_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  bus_enable_q, bus_enable_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wr_data_q, bus_wr_data_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] a_cur, b_cur, op_word;
    logic [2:0]            op_cur;
    logic                  need_a, need_b, need_op;

    // In IDLE the operands come straight from the command port so the first
    // write can be set up on the accept edge itself.
    assign accept  = (state_q == S_IDLE) && bus.cmd_valid && cmd_ready_q;
    assign a_cur   = (state_q == S_IDLE) ? bus.cmd_a  : a_q;
    assign b_cur   = (state_q == S_IDLE) ? bus.cmd_b  : b_q;
    assign op_cur  = (state_q == S_IDLE) ? bus.cmd_op : op_q;
    assign op_word = {{(DATA_WIDTH-3){1'b0}}, op_cur};
    assign need_a  = (a_cur   != sh_a_q);
    assign need_b  = (b_cur   != sh_b_q);
    assign need_op = (op_word != sh_op_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            sh_a_q        <= '1;
            sh_b_q        <= '1;
            sh_op_q       <= '1;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_div0_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            bus_enable_q  <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            sh_a_q        <= sh_a_d;
            sh_b_q        <= sh_b_d;
            sh_op_q       <= sh_op_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_div0_q    <= rsp_div0_d;
            rsp_err_q     <= rsp_err_d;
            bus_enable_q  <= bus_enable_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = first_write(need_a, need_b, need_op);
            S_WR_A:    state_d = first_write(1'b0, need_b, need_op);
            S_WR_B:    state_d = first_write(1'b0, 1'b0, need_op);
            S_WR_OP:   state_d = S_WR_EXEC;
            S_WR_EXEC: state_d = S_WAIT;
            S_WAIT:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_RESP:    if (bus.rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Registered outputs are loaded from the upcoming state so each one is
    // valid for exactly the cycle that state occupies.
    always_comb begin
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        sh_a_d        = sh_a_q;
        sh_b_d        = sh_b_q;
        sh_op_d       = sh_op_q;
        rsp_result_d  = rsp_result_q;
        rsp_div0_d    = rsp_div0_q;
        rsp_err_d     = rsp_err_q;
        bus_enable_d  = 1'b0;
        bus_addr_d    = '0;
        bus_wr_data_d = '0;

        if (accept) begin
            a_d  = bus.cmd_a;
            b_d  = bus.cmd_b;
            op_d = bus.cmd_op;
        end

        case (state_q)
            S_WR_A:  sh_a_d  = a_q;
            S_WR_B:  sh_b_d  = b_q;
            S_WR_OP: sh_op_d = {{(DATA_WIDTH-3){1'b0}}, op_q};
            S_CAPTURE: begin
                rsp_result_d = bus.bus_res_out;
                rsp_div0_d   = (op_q == 3'(OP_DIV)) && (b_q == '0);
                rsp_err_d    = (op_q > 3'(OP_DIV));
            end
            default: ;
        endcase

        case (state_d)
            S_WR_A: begin
                bus_enable_d  = 1'b1;
                bus_addr_d    = ADDR_WIDTH'(ADDR_A);
                bus_wr_data_d = a_cur;
            end
            S_WR_B: begin
                bus_enable_d  = 1'b1;
                bus_addr_d    = ADDR_WIDTH'(ADDR_B);
                bus_wr_data_d = b_cur;
            end
            S_WR_OP: begin
                bus_enable_d  = 1'b1;
                bus_addr_d    = ADDR_WIDTH'(ADDR_OP);
                bus_wr_data_d = op_word;
            end
            S_WR_EXEC: begin
                bus_enable_d  = 1'b1;
                bus_addr_d    = ADDR_WIDTH'(ADDR_EXEC);
                bus_wr_data_d = DATA_WIDTH'(EXEC_DATA);
            end
            default: ;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // cmd_ready is gated so it reads 0 during reset yet is 1 right after release.
    assign bus.cmd_ready   = cmd_ready_q & ~rst;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_div0    = rsp_div0_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.bus_enable  = bus_enable_q;
    assign bus.bus_rd_wr   = 1'b0;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wr_data = bus_wr_data_q;

endmodule
